// File: rtl/sync_mem_loader_if.sv
// Stream-in, memory-write and load-status bundle between a word source and the loader.
// The master side drives the stream and start; the slave side is the loader.
interface sync_mem_loader_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    logic              start;
    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic [31:0]       size;
    logic              loaded;
    logic              sum_start;
    logic              overflow;

    modport master (
        output start, in_data, in_valid, in_last,
        input  in_ready, mem_we, mem_addr, mem_din, size, loaded, sum_start, overflow
    );

    modport slave (
        input  start, in_data, in_valid, in_last,
        output in_ready, mem_we, mem_addr, mem_din, size, loaded, sum_start, overflow
    );
endinterface

// File: rtl/sync_mem_loader.sv
// Writes an accepted valid/ready word stream to memory addresses 0.. in order; zero-latency write path,
// in_ready only while loading; on in_last or full memory reports size, raises loaded, pulses sum_start.
module sync_mem_loader #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 1024
) (
    input logic               clk,
    input logic               reset,
    sync_mem_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [AWIDTH:0] LAST_PTR = (AWIDTH+1)'(DEPTH - 1);

    state_t          state;
    state_t          state_nxt;
    logic [AWIDTH:0] ptr;
    logic [AWIDTH:0] ptr_inc;
    logic [31:0]     size_q;
    logic            ovf_q;
    logic            pulse_q;
    logic            ready;
    logic            accept;
    logic            finish;
    logic            load_go;

    assign ready   = (state == LOAD);
    assign accept  = bus.in_valid & ready;
    assign load_go = bus.start & (state != LOAD);
    assign ptr_inc = ptr + (AWIDTH+1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = LOAD;
            LOAD: begin
                // The word landing at DEPTH-1 fills memory even without in_last
                if (accept && (bus.in_last || ptr == LAST_PTR)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: if (bus.start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr     <= '0;
            size_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= finish;
            if (load_go) begin
                ptr    <= '0;
                size_q <= '0;
                ovf_q  <= 1'b0;
            end else if (accept) begin
                ptr <= ptr_inc;
                if (finish) begin
                    size_q <= 32'(ptr_inc);
                    ovf_q  <= ~bus.in_last;
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = accept;
    assign bus.mem_addr  = ptr[AWIDTH-1:0];
    assign bus.mem_din   = bus.in_data;
    assign bus.size      = size_q;
    assign bus.loaded    = (state == DONE);
    assign bus.sum_start = pulse_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sync_mem_loader.sv
// Randomized bench for sync_mem_loader: a stand-in memory captures the write port and a
// word-level model (load-open flag, word count, expected memory image) predicts every output each cycle.
module tb_sync_mem_loader;
    localparam int AWIDTH = 10;
    localparam int DWIDTH = 32;
    localparam int DEPTH  = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sync_mem_loader_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

    sync_mem_loader #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream synchronous memory
    logic [DWIDTH-1:0] cap_mem [DEPTH];
    int                cap_wr = 0;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            cap_mem[bus.mem_addr] <= bus.mem_din;
            cap_wr                <= cap_wr + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int rdy_cnt = 0;

    bit                m_open, m_loaded, m_pulse, m_ovf;
    int                m_cnt, m_size;
    logic [DWIDTH-1:0] exp_mem [DEPTH];
    logic [DWIDTH-1:0] cur_d;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_loaded = 0; m_pulse = 0; m_ovf = 0; m_cnt = 0; m_size = 0;
    endtask

    // Word-level rules: an open load takes every valid word until in_last or DEPTH words
    task automatic model_edge(input bit v, input logic [DWIDTH-1:0] d, input bit l, input bit s);
        m_pulse = 0;
        if (m_open) begin
            if (v) begin
                exp_mem[m_cnt] = d;
                m_cnt++;
                if (l || m_cnt == DEPTH) begin
                    m_open = 0; m_loaded = 1; m_pulse = 1; m_size = m_cnt; m_ovf = !l;
                end
            end
        end else if (s) begin
            m_open = 1; m_loaded = 0; m_cnt = 0; m_size = 0; m_ovf = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        bit we_exp;
        we_exp = bus.in_valid & m_open;
        check_val({tag, ".in_ready"},  bus.in_ready,  m_open);
        check_val({tag, ".mem_we"},    bus.mem_we,    we_exp);
        check_val({tag, ".mem_addr"},  bus.mem_addr,  m_cnt % DEPTH);
        check_val({tag, ".loaded"},    bus.loaded,    m_loaded);
        check_val({tag, ".sum_start"}, bus.sum_start, m_pulse);
        check_val({tag, ".size"},      bus.size,      m_size);
        check_val({tag, ".overflow"},  bus.overflow,  m_ovf);
        if (we_exp) check_val({tag, ".mem_din"}, bus.mem_din, cur_d);
    endtask

    // One clock: drive just after a rising edge, check on the falling edge, advance model at the rising edge
    task automatic cycle(input bit v, input logic [DWIDTH-1:0] d, input bit l, input bit s);
        bus.in_valid = v; bus.in_data = d; bus.in_last = l; bus.start = s; cur_d = d;
        @(negedge clk);
        compare_all("cyc");
        if (bus.in_ready) rdy_cnt++;
        @(posedge clk);
        model_edge(v, d, l, s);
        #1;
    endtask

    task automatic pulse_start();
        cycle(0, '0, 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, '0, 0, 0);
    endtask

    task automatic send(input logic [DWIDTH-1:0] w[$], input bit mark_last,
                        input int gap_lo, input int gap_hi, input int start_idx);
        for (int i = 0; i < w.size(); i++) begin
            int g = (i == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo));
            // in_last toggles randomly during gaps: it must be ignored without in_valid
            repeat (g) cycle(0, $urandom, 1'($urandom_range(1, 0)), 0);
            cycle(1, w[i], mark_last && (i == w.size() - 1), i == start_idx);
        end
    endtask

    task automatic mem_check(input string tag);
        for (int i = 0; i < m_size; i++) check_val({tag, ".mem"}, cap_mem[i], exp_mem[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DWIDTH-1:0] q[$];
        int wr0;

        bus.start = 0; bus.in_valid = 0; bus.in_last = 0; bus.in_data = '0; cur_d = '0;
        model_reset();
        #2;
        compare_all("reset");
        #10 reset = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // Contiguous 4-word load
        rdy_cnt = 0; wr0 = cap_wr;
        pulse_start();
        q = {32'd1, 32'd2, 32'd3, 32'd4};
        send(q, 1, 0, 0, -1);
        idle(3);
        check_val("contig.rdy_cycles", rdy_cnt, 4);
        check_val("contig.size", bus.size, 4);
        check_val("contig.writes", cap_wr - wr0, 4);
        mem_check("contig");

        // Two-cycle bubbles between words
        wr0 = cap_wr;
        pulse_start();
        q = {32'h10, 32'h20, 32'h30};
        send(q, 1, 2, 2, -1);
        idle(2);
        check_val("bubble.size", bus.size, 3);
        check_val("bubble.writes", cap_wr - wr0, 3);
        mem_check("bubble");

        // Overflow: 1100 words with no in_last
        wr0 = cap_wr;
        q = {};
        for (int i = 0; i < 1100; i++) q.push_back($urandom);
        pulse_start();
        send(q, 0, 0, 0, -1);
        idle(2);
        check_val("ovf.size", bus.size, DEPTH);
        check_val("ovf.flag", bus.overflow, 1);
        check_val("ovf.writes", cap_wr - wr0, DEPTH);
        mem_check("ovf");

        // Single word, restart from DONE, then a 2-word load
        pulse_start();
        q = {32'hABCD};
        send(q, 1, 0, 0, -1);
        idle(1);
        check_val("single.size", bus.size, 1);
        mem_check("single");
        pulse_start();
        check_val("restart.loaded", bus.loaded, 0);
        check_val("restart.size", bus.size, 0);
        q = {$urandom, $urandom};
        send(q, 1, 0, 1, -1);
        idle(2);
        check_val("restart2.size", bus.size, 2);
        mem_check("restart2");

        // Asynchronous reset midway through a 10-word stream
        pulse_start();
        q = {};
        for (int i = 0; i < 5; i++) q.push_back($urandom);
        send(q, 0, 0, 0, -1);
        bus.in_valid = 1; bus.in_data = $urandom; bus.in_last = 0; cur_d = bus.in_data;
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        for (int i = 0; i < 5; i++) check_val("async_rst.kept", cap_mem[i], q[i]);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        repeat (3) cycle(1, $urandom, 0, 0);
        pulse_start();
        q = {$urandom, $urandom, $urandom};
        send(q, 1, 0, 1, -1);
        idle(2);
        check_val("post_rst.size", bus.size, 3);
        mem_check("post_rst");

        // start during LOAD (coinciding with a handshake) is ignored
        pulse_start();
        q = {};
        for (int i = 0; i < 6; i++) q.push_back($urandom);
        send(q, 1, 0, 1, 2);
        idle(2);
        check_val("ign_start.size", bus.size, 6);
        mem_check("ign_start");

        // Random loads with random bubbles and a stray start
        repeat (5) begin
            int n;
            n = $urandom_range(12, 1);
            q = {};
            for (int i = 0; i < n; i++) q.push_back($urandom);
            wr0 = cap_wr;
            pulse_start();
            send(q, 1, 0, 3, int'($urandom_range(n - 1, 0)));
            idle(2);
            check_val("rand.size", bus.size, n);
            check_val("rand.writes", cap_wr - wr0, n);
            mem_check("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_mem_loader.md
# sync_mem_loader

Upstream feeder for `sum_sync_mem`. Accepts a valid/ready word stream, writes each accepted word into consecutive addresses of the synchronous memory's write port starting at address 0, and counts them. When the stream ends (`in_last`) or the memory fills, it reports the word count on `size`, raises `loaded`, and pulses `sum_start` so the downstream summer can begin reading.

## Interface
- `AWIDTH`, 10, memory address width
- `DWIDTH`, 32, data word width
- `DEPTH`, 1024, number of memory words; `DEPTH <= 2**AWIDTH`
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; asserting it (0) clears all state immediately, independent of `clk`
- `start`  in  1  begin a load; honoured in IDLE and DONE only
- `in_data`  in  DWIDTH  stream word
- `in_valid`  in  1  `in_data` and `in_last` are valid
- `in_last`  in  1  current word is the final word of the stream
- `in_ready`  out  1  loader can accept a word this cycle
- `mem_we`  out  1  write enable to the synchronous memory
- `mem_addr`  out  AWIDTH  write address
- `mem_din`  out  DWIDTH  write data
- `size`  out  32  number of words written in the last completed load
- `loaded`  out  1  load complete; `size` and memory contents are stable
- `sum_start`  out  1  one-cycle pulse on entry to DONE
- `overflow`  out  1  load ended because memory filled without `in_last`

## Operation
- Handshake: a word is accepted when `in_valid & in_ready` is 1 at a rising edge.
- States: IDLE, LOAD, DONE.
- IDLE:
  - `in_ready` = 0.
  - `start` = 1 → LOAD; clears `ptr`, `size` and `overflow`.
- LOAD:
  - `in_ready` = 1.
  - On each accepted word: `ptr` increments by 1.
  - If the accepted word has `in_last` = 1 → DONE.
  - Else, if `ptr == DEPTH-1` → DONE and `overflow` = 1. Any further words are not accepted.
  - `start` is ignored in LOAD.
- DONE:
  - `in_ready` = 0.
  - `loaded` = 1.
  - `size` holds the number of accepted words, range 1..DEPTH.
  - `start` = 1 → LOAD; clears `ptr`, `size` and `overflow`, and drops `loaded`.
- Memory write port is combinational from the handshake:
  - `mem_we = in_valid & in_ready`
  - `mem_addr = ptr`
  - `mem_din = in_data`
- The memory captures the write on the same edge that accepts the word.
- `size` is `ptr`, zero-extended to 32 bits, latched on entry to DONE. Use an AWIDTH+1-bit internal count so that `size` = DEPTH is representable.
- `in_last` is ignored when `in_valid` = 0.
- Memory contents are never cleared by this block.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `in_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `size` = 0, `loaded` = 0, `sum_start` = 0, `overflow` = 0.
- `start` sampled at edge N → `in_ready` = 1 from cycle N+1. The first word can be accepted at edge N+1.
- Last word accepted at edge M:
  - Memory write commits at edge M.
  - `loaded`, `sum_start` and `size` become valid in cycle M+1.
  - `sum_start` returns to 0 in cycle M+2.
- Back-to-back input: one word per cycle with no bubbles. `in_valid` gaps only stall the load.
- Reset mid-LOAD:
  - Outputs return to reset values asynchronously.
  - Words already written stay in memory.
  - Any partially written stream is abandoned.
- `start` and a handshake in the same LOAD cycle: the word is accepted and `start` is ignored.

## Test plan
- Contiguous load: pulse `start`, stream words 1..4 with `in_last` on word 4, `in_valid` held high → `in_ready` high for exactly 4 cycles; memory addresses 0..3 hold 1..4; `size` = 4; `loaded` = 1 and one-cycle `sum_start` in the cycle after word 4; `overflow` = 0.
- Bubbles: stream 0x10, 0x20, 0x30 (last) with `in_valid` low for 2 cycles between each word → addresses 0..2 = 0x10, 0x20, 0x30; `size` = 3; `mem_we` never high when `in_valid` is low.
- Overflow: stream 1100 words, none marked `in_last` → 1024 writes to addresses 0..1023; `size` = 1024; `overflow` = 1; `in_ready` = 0 from the cycle after the 1024th word; words 1025+ are never accepted.
- Single word with restart: load one word 0xABCD (last) → `size` = 1. Then pulse `start` in DONE → `loaded` drops and `size` clears to 0. A new 2-word load then yields `size` = 2.
- Reset mid-load: assert `reset` = 0 between edges after 5 of 10 words → all outputs return to reset values without waiting for a clock edge; state = IDLE. After release, `start` is required before `in_ready` rises again.
- Ignored `start`: pulse `start` in LOAD after word 2 of a 6-word stream → `ptr` does not reset; final `size` = 6.
